// File: rtl/ula.sv
`default_nettype none
// ============================================================================
//  Module      : ula
//  Description : 32-bit arithmetic/logic unit. Eight operations selected by a
//                3-bit function code; result and status flags are registered
//                with one cycle of latency and one operation per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  f,
    output logic [31:0] saida,
    output logic        zero,
    output logic        negativo,
    output logic        carry,
    output logic        overflow
);

    // Function codes
    localparam logic [2:0] c_f_add  = 3'b000;
    localparam logic [2:0] c_f_sub  = 3'b001;
    localparam logic [2:0] c_f_and  = 3'b010;
    localparam logic [2:0] c_f_or   = 3'b011;
    localparam logic [2:0] c_f_xor  = 3'b100;
    localparam logic [2:0] c_f_nota = 3'b101;
    localparam logic [2:0] c_f_pass = 3'b110;
    localparam logic [2:0] c_f_notb = 3'b111;

    // Next-state values
    logic [31:0] w_saida_d;
    logic        w_zero_d;
    logic        w_negativo_d;
    logic        w_carry_d;
    logic        w_overflow_d;

    // Intermediate arithmetic; bit 32 of the difference is the unsigned borrow
    logic [32:0] w_sum;
    logic [32:0] w_diff;

    // Registered outputs
    logic [31:0] r_saida_q;
    logic        r_zero_q;
    logic        r_negativo_q;
    logic        r_carry_q;
    logic        r_overflow_q;

    // Compute result and flags for the operands present this cycle
    always_comb begin
        w_sum        = {1'b0, A} + {1'b0, B};
        w_diff       = {1'b0, A} - {1'b0, B};
        w_saida_d    = 32'h0000_0000;
        w_carry_d    = 1'b0;
        w_overflow_d = 1'b0;
        case (f)
            c_f_add: begin
                w_saida_d    = w_sum[31:0];
                w_carry_d    = w_sum[32];
                // Same-sign operands producing a result of the other sign
                w_overflow_d = (A[31] == B[31]) && (w_sum[31] != A[31]);
            end
            c_f_sub: begin
                w_saida_d    = w_diff[31:0];
                w_carry_d    = w_diff[32];
                // Opposite-sign operands where the result sign departs from A
                w_overflow_d = (A[31] != B[31]) && (w_diff[31] != A[31]);
            end
            c_f_and:  w_saida_d = A & B;
            c_f_or:   w_saida_d = A | B;
            c_f_xor:  w_saida_d = A ^ B;
            c_f_nota: w_saida_d = ~A;
            c_f_pass: w_saida_d = A;
            c_f_notb: w_saida_d = ~B;
            default:  w_saida_d = 32'h0000_0000;
        endcase
        w_zero_d     = (w_saida_d == 32'h0000_0000);
        w_negativo_d = w_saida_d[31];
    end

    // Capture result and flags; reset wins over the operation on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_saida_q    <= 32'h0000_0000;
            r_zero_q     <= 1'b0;
            r_negativo_q <= 1'b0;
            r_carry_q    <= 1'b0;
            r_overflow_q <= 1'b0;
        end else begin
            r_saida_q    <= w_saida_d;
            r_zero_q     <= w_zero_d;
            r_negativo_q <= w_negativo_d;
            r_carry_q    <= w_carry_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    assign saida    = r_saida_q;
    assign zero     = r_zero_q;
    assign negativo = r_negativo_q;
    assign carry    = r_carry_q;
    assign overflow = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ula.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ula
//  Description : Self-checking bench for ula. Expected results are queued
//                when stimulus is driven and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ula;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  f;
    logic [31:0] saida;
    logic        zero;
    logic        negativo;
    logic        carry;
    logic        overflow;

    int total;
    int bad;

    // Expected record: {saida, zero, negativo, carry, overflow}
    logic [35:0] sb_q[$];
    string       nm_q[$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  fn;
        logic [35:0] exp;
    } vec_t;

    vec_t tbl[14];

    ula u_dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .f        (f),
        .saida    (saida),
        .zero     (zero),
        .negativo (negativo),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built on 64-bit arithmetic
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] fn);
        logic [63:0] ua;
        logic [63:0] ub;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [31:0] r;
        logic        c;
        logic        v;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        r  = 32'h0;
        case (fn)
            3'd0: begin
                r  = a + b;
                c  = (ua + ub) > 64'hFFFF_FFFF;
                sr = sa + sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                r  = a - b;
                c  = ua < ub;
                sr = sa - sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = a;
            default: r = ~b;
        endcase
        return {r, (r == 32'h0), r[31], c, v};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then check after the edge
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] fn, input logic [35:0] exp, input string name);
        logic [35:0] e;
        logic [35:0] act;
        string       n;
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        f   = fn;
        sb_q.push_back(exp);
        nm_q.push_back(name);
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        n   = nm_q.pop_front();
        act = {saida, zero, negativo, carry, overflow};
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got saida=%h z=%b n=%b c=%b v=%b, want saida=%h z=%b n=%b c=%b v=%b",
                     n, act[35:4], act[3], act[2], act[1], act[0],
                     e[35:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        A     = 32'h0;
        B     = 32'h0;
        f     = 3'd0;

        tbl[0]  = '{32'd3,         32'd9,         3'd0, {32'd12,         4'b0000}};
        tbl[1]  = '{32'd6,         32'd2,         3'd1, {32'd4,          4'b0000}};
        tbl[2]  = '{32'd0,         32'd1,         3'd1, {32'hFFFF_FFFF,  4'b0110}};
        tbl[3]  = '{32'd5,         32'd5,         3'd1, {32'd0,          4'b1000}};
        tbl[4]  = '{32'hC,         32'hA,         3'd2, {32'h8,          4'b0000}};
        tbl[5]  = '{32'h3,         32'hC,         3'd3, {32'hF,          4'b0000}};
        tbl[6]  = '{32'hA,         32'h6,         3'd4, {32'hC,          4'b0000}};
        tbl[7]  = '{32'hD,         32'h7,         3'd5, {32'hFFFF_FFF2,  4'b0100}};
        tbl[8]  = '{32'h3,         32'h55,        3'd6, {32'h3,          4'b0000}};
        tbl[9]  = '{32'h12,        32'hF,         3'd7, {32'hFFFF_FFF0,  4'b0100}};
        tbl[10] = '{32'h7FFF_FFFF, 32'd1,         3'd0, {32'h8000_0000,  4'b0101}};
        tbl[11] = '{32'hFFFF_FFFF, 32'd1,         3'd0, {32'h0,          4'b1010}};
        tbl[12] = '{32'h8000_0000, 32'd1,         3'd1, {32'h7FFF_FFFF,  4'b0001}};
        tbl[13] = '{32'd1,         32'h8000_0000, 3'd1, {32'h8000_0001,  4'b0111}};

        // Reset held for two cycles with nonzero operands
        step(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 3'd0, 36'h0, "reset0");
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 36'h0, "reset1");

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            step(1'b0, tbl[i].a, tbl[i].b, tbl[i].fn, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back issue of all eight function codes
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'hF0F0_0009, 32'h0FF0_0005, 3'(k),
                 model(32'hF0F0_0009, 32'h0FF0_0005, 3'(k)), $sformatf("b2b_f%0d", k));
        end

        // Reset in mid-stream: the operation presented on the reset edge is dropped
        step(1'b0, 32'd100, 32'd1,  3'd0, model(32'd100, 32'd1, 3'd0), "pre_rst");
        step(1'b1, 32'd7,   32'd7,  3'd3, 36'h0,                        "mid_rst");
        step(1'b0, 32'd20,  32'd22, 3'd1, model(32'd20, 32'd22, 3'd1), "post_rst");
        step(1'b0, 32'd0,   32'd0,  3'd0, {32'd0, 4'b1000},             "post_rst_zero");

        // Random operations, biased toward sign boundaries
        for (int j = 0; j < 40; j++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [2:0]  rf;
            ra = $urandom;
            rb = $urandom;
            rf = 3'($urandom_range(0, 7));
            if (j % 4 == 0) ra[30:0] = {31{ra[0]}};
            if (j % 5 == 0) rb = ra;
            step(1'b0, ra, rb, rf, model(ra, rb, rf), $sformatf("rand%0d", j));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ula.md
# ula

32-bit arithmetic/logic unit with a registered result and status flags. Each rising clock edge applies one of eight operations, selected by a 3-bit function code, to two 32-bit operands. It sits in the datapath between operand sources (register file or immediate mux) and the writeback/branch logic. The flags drive condition evaluation downstream.

## Interface

Parameters:
- None. Width is fixed at 32 bits and the function code at 3 bits.

Ports:
- `clk`  input  1  single system clock; all state updates on its rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `A`  input  32  operand A.
- `B`  input  32  operand B.
- `f`  input  3  function select.
- `saida`  output  32  registered result.
- `zero`  output  1  registered flag; high when the result is all zeros.
- `negativo`  output  1  registered flag; equals bit 31 of the result.
- `carry`  output  1  registered flag; carry out on add, borrow on subtract.
- `overflow`  output  1  registered flag; two's-complement signed overflow on add/subtract.

## Operation

Function map (f → result):
- `000`: A + B, modulo 2^32.
- `001`: A − B, modulo 2^32.
- `010`: A & B, bitwise.
- `011`: A | B, bitwise.
- `100`: A ^ B, bitwise.
- `101`: ~A.
- `110`: A (pass-through).
- `111`: ~B.

Flag rules:
- `zero` = (result == 0) for every function.
- `negativo` = result[31] for every function.
- `carry`:
  - add: bit 32 of the 33-bit unsigned sum.
  - sub: 1 when A < B unsigned (borrow), else 0.
  - all logic and pass functions: 0.
- `overflow`:
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from A.
  - all other functions: 0.
- All arithmetic is combinational from A, B and f. Only the outputs are registered. There is no other internal state.

## Timing

- Reset is synchronous and active-high. On a rising edge with `rst`=1:
  - `saida` = 0x00000000.
  - `zero` = 0, `negativo` = 0, `carry` = 0, `overflow` = 0.
- Reset has priority over computation. Inputs present on a reset edge are discarded and do not appear later.
- Latency is 1 cycle. The result and flags for A/B/f sampled at edge N are visible right after edge N, and are held until edge N+1.
- Throughput is one operation per cycle. There is no handshake; a new operation can be issued every cycle.
- If inputs change between edges, only the values present at the rising edge are captured.
- Releasing `rst` mid-stream: the first non-reset edge captures the operands present at that edge.
- f is always fully decoded; there is no illegal code.

## Test plan

- Apply `rst`=1 for 2 cycles with nonzero A/B, then sample → `saida`=0 and all flags 0. Deassert and apply A=3, B=9, f=000 → next cycle `saida`=12, zero=0, carry=0, overflow=0.
- Arithmetic:
  - A=6, B=2, f=001 → `saida`=4, carry=0.
  - A=0, B=1, f=001 → `saida`=0xFFFFFFFF, carry=1, negativo=1.
  - A=5, B=5, f=001 → `saida`=0, zero=1.
- Logic ops:
  - A=0b1100, B=0b1010, f=010 → 0b1000.
  - A=0b0011, B=0b1100, f=011 → 0b1111.
  - A=0b1010, B=0b0110, f=100 → 0b1100.
  - In all three cases carry=0 and overflow=0.
- Unary and pass ops:
  - A=0b1101, f=101 → 0xFFFFFFF2, negativo=1.
  - A=0b0011, f=110 → 3.
  - B=0b1111, f=111 → 0xFFFFFFF0.
- Overflow and carry boundaries:
  - A=0x7FFFFFFF, B=1, f=000 → 0x80000000, overflow=1, negativo=1, carry=0.
  - A=0xFFFFFFFF, B=1, f=000 → 0, carry=1, zero=1, overflow=0.
  - A=0x80000000, B=1, f=001 → 0x7FFFFFFF, overflow=1.
- Back-to-back issue with the 8 function codes on consecutive cycles → each result appears exactly one cycle after its inputs. Asserting `rst` in the middle of the sequence → outputs are 0 on the following cycle and the in-flight operation is lost.
